// File: rtl/instr_sequencer.sv
// rtl/instr_sequencer.sv - instruction fetch/decode/execute control sequencer
//
// Purpose: fetches 16-bit instructions into an instruction register. It decodes
// the opcode in bits [15:12] and starts exactly one execution FSM through a
// one-hot select. It then waits for that unit's done pulse. The block also
// flags illegal opcodes and execution timeouts, and it handles HALT.
//
// Optional feature macro: SEQ_STEP_EN (adds the step input and a STEP_WAIT
// state between RETIRE and FETCH for single-stepping).
//
// Ports:
//   clk          in   system clock, rising edge
//   rst          in   asynchronous active-low reset
//   instr_in     in   [15:0] instruction word from program memory
//   instr_valid  in   instr_in valid (sampled only in FETCH)
//   unit_done    in   [15:0] done pulses, bit n = opcode n
//   resume       in   leave HALT
//   clear_err    in   leave ERROR, clears sticky flags
//   step         in   (SEQ_STEP_EN only) release STEP_WAIT
//   fetch_req    out  request next instruction
//   if_active    out  fetch phase active, execution FSMs held idle
//   instruction  out  [15:0] instruction register
//   unit_sel     out  [15:0] one-hot select of active execution FSM
//   retire       out  one-cycle pulse per completed instruction
//   instr_count  out  [15:0] retired-instruction counter
//   halted       out  in HALT
//   illegal_op   out  sticky illegal-opcode flag
//   timeout_err  out  sticky execution-timeout flag
module instr_sequencer #(
    parameter int unsigned TIMEOUT_CYCLES = 15,
    parameter logic [15:0] LEGAL_MASK     = 16'h00FF,
    parameter logic [3:0]  HALT_OPCODE    = 4'hF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] instr_in,
    input  logic        instr_valid,
    input  logic [15:0] unit_done,
    input  logic        resume,
    input  logic        clear_err,
`ifdef SEQ_STEP_EN
    input  logic        step,
`endif
    output logic        fetch_req,
    output logic        if_active,
    output logic [15:0] instruction,
    output logic [15:0] unit_sel,
    output logic        retire,
    output logic [15:0] instr_count,
    output logic        halted,
    output logic        illegal_op,
    output logic        timeout_err
);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_FETCH     = 3'd1,
        S_DECODE    = 3'd2,
        S_EXEC      = 3'd3,
        S_RETIRE    = 3'd4,
        S_HALT      = 3'd5,
        S_ERROR     = 3'd6,
        S_STEP_WAIT = 3'd7
    } state_t;

    state_t      r_state;
    state_t      w_next_state;
    logic [15:0] r_instruction;
    logic [15:0] r_unit_sel;
    logic [15:0] r_instr_count;
    logic [7:0]  r_timer;
    logic        r_illegal;
    logic        r_timeout;
    logic [3:0]  w_opcode;
    logic        w_timer_expired;

    assign w_opcode        = r_instruction[15:12];
    assign w_timer_expired = (r_timer == 8'(TIMEOUT_CYCLES - 1));

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state logic
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE:   w_next_state = S_FETCH;
            S_FETCH:  if (instr_valid) w_next_state = S_DECODE;
            S_DECODE: begin
                // HALT is checked first so it works even when its mask bit is clear
                if (w_opcode == HALT_OPCODE)     w_next_state = S_HALT;
                else if (!LEGAL_MASK[w_opcode])  w_next_state = S_ERROR;
                else                             w_next_state = S_EXEC;
            end
            S_EXEC: begin
                // done wins over a timeout landing in the same cycle
                if (unit_done[w_opcode])         w_next_state = S_RETIRE;
                else if (w_timer_expired)        w_next_state = S_ERROR;
            end
`ifdef SEQ_STEP_EN
            S_RETIRE:    w_next_state = S_STEP_WAIT;
            S_STEP_WAIT: if (step) w_next_state = S_FETCH;
`else
            S_RETIRE:    w_next_state = S_FETCH;
`endif
            S_HALT:   if (resume)    w_next_state = S_FETCH;
            S_ERROR:  if (clear_err) w_next_state = S_FETCH;
            default:  w_next_state = S_IDLE;
        endcase
    end

    // Output decode
    always_comb begin
        fetch_req = 1'b0;
        if_active = 1'b0;
        retire    = 1'b0;
        halted    = 1'b0;
        case (r_state)
            S_FETCH: begin
                fetch_req = 1'b1;
                if_active = 1'b1;
            end
`ifdef SEQ_STEP_EN
            S_STEP_WAIT: if_active = 1'b1;
`endif
            S_RETIRE: retire = 1'b1;
            S_HALT:   halted = 1'b1;
            default:  ;
        endcase
    end

    // Datapath registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_instruction <= '0;
            r_unit_sel    <= '0;
            r_instr_count <= '0;
            r_timer       <= '0;
            r_illegal     <= 1'b0;
            r_timeout     <= 1'b0;
        end else begin
            if (r_state == S_FETCH && instr_valid) begin
                r_instruction <= instr_in;
            end
            // Select is loaded on EXEC entry and held steady until EXEC is left
            r_unit_sel <= (w_next_state == S_EXEC) ? (16'd1 << w_opcode) : 16'd0;
            if (r_state == S_DECODE) begin
                r_timer <= '0;
            end else if (r_state == S_EXEC) begin
                r_timer <= r_timer + 8'd1;
            end
            if (r_state == S_RETIRE) begin
                r_instr_count <= r_instr_count + 16'd1;
            end
            if (r_state == S_DECODE && w_next_state == S_ERROR) begin
                r_illegal <= 1'b1;
            end
            if (r_state == S_EXEC && w_next_state == S_ERROR) begin
                r_timeout <= 1'b1;
            end
            if (r_state == S_ERROR && clear_err) begin
                r_illegal <= 1'b0;
                r_timeout <= 1'b0;
            end
        end
    end

    assign instruction = r_instruction;
    assign unit_sel    = r_unit_sel;
    assign instr_count = r_instr_count;
    assign illegal_op  = r_illegal;
    assign timeout_err = r_timeout;

endmodule
